snax_simbacore_csr_manager: RTL and testbench
=============================================

# snax_simbacore_csr_manager

Initiator side of the SimbaCore configuration handshake. Sits between the Snitch core's CSR request/response port and the SimbaCore shell wrapper's `csr_reg_set_*` / `csr_reg_ro_set_*` ports. It holds the read/write configuration registers and launches them to the accelerator as one valid/ready transaction. It also exposes accelerator read-only values, a status word and a busy-cycle performance counter back to the core.

## Interface
Parameters:
- RegRWCount, 5, number of RW config registers (mode, seqLen, dModel, dtRank, dInner)
- RegROCount, 2, number of RO registers driven by the accelerator
- RegDataWidth, 32, register width
- RegAddrWidth, 32, CSR address width (word index, not byte address)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, reset is synchronous and active-low
- csr_req_addr_i  in  RegAddrWidth  register word index
- csr_req_data_i  in  RegDataWidth  write data
- csr_req_write_i  in  1  1 = write, 0 = read
- csr_req_valid_i  in  1  request valid
- csr_req_ready_o  out  1  request accepted
- csr_rsp_data_o  out  RegDataWidth  read data
- csr_rsp_valid_o  out  1  read response valid
- csr_rsp_ready_i  in  1  core accepts response
- csr_reg_set_o  out  [RegRWCount][RegDataWidth]  config to accelerator
- csr_reg_set_valid_o  out  1  launch valid
- csr_reg_set_ready_i  in  1  accelerator accepts config
- csr_reg_ro_set_i  in  [RegROCount][RegDataWidth]  accelerator RO values
- acc_busy_i  in  1  accelerator is processing

## Operation
Address map, using full-width compare:
- 0..RW-1: RW config registers.
- RW..RW+RO-1: RO passthrough of csr_reg_ro_set_i. Writes are ignored.
- LAUNCH = RW+RO:
  - Write with data[0]=1 starts a launch; data[0]=0 is ignored.
  - Read returns {30'b0, acc_busy_i, pending}.
- PERF = RW+RO+1:
  - Read returns the busy-cycle counter.
  - A write of any value clears it to 0.
- Other addresses: reads return 0, writes are ignored. Both are still acknowledged normally.

Request handling:
- Writes complete on the request handshake and produce no response.
- Reads produce exactly one response.

FSM with two states:
- IDLE: a launch write moves to PENDING.
- PENDING: csr_reg_set_valid_o=1. On csr_reg_set_ready_i=1, return to IDLE, clear the perf counter, and arm counting.

Rules while PENDING:
- csr_reg_set_o must not change while valid is high.
- Every write request is stalled: csr_req_ready_o=0 when csr_req_write_i=1.
- Reads are still served.

Perf counter:
- Increments by 1 on each cycle in which it is armed and acc_busy_i=1.
- Saturates at all-ones.
- Disarmed when acc_busy_i falls after having been seen high.
- A PERF write in the same cycle as an increment wins (result is 0).

## Timing
- Reset values: all RW registers 0, state IDLE, counter 0, not armed, csr_rsp_valid_o=0, csr_rsp_data_o=0, csr_reg_set_valid_o=0.
- csr_req_ready_o = !(rsp_valid && !rsp_ready) && !(PENDING && write). It is combinational and not a registered output.
- Read latency is 1 cycle: a request handshake in cycle N gives rsp_valid in N+1, with data sampled at N.
  - rsp_valid holds, with data stable, until rsp_ready.
  - Back-to-back reads at full throughput are possible when rsp_ready is held high.
- Launch: the write is accepted in cycle N and csr_reg_set_valid_o=1 from N+1. Minimum handshake is N+1 if ready is already high.
- Status read in the cycle of the launch handshake returns pending=1. Status is sampled before the update.
- Reset asserted mid-launch: valid=0 from the next edge and no handshake is completed.
- csr_reg_set_ready_i while IDLE is ignored.

## Structure
- Package `snax_simbacore_csr_pkg`:
  - State enum `csr_state_e` {IDLE, PENDING}.
  - Address offset constants `LaunchAddr`, `PerfAddr` as functions of RW/RO counts.
  - Status bit positions.
- Single module, no sub-module. The perf counter is inline; a generic saturating counter from the common cells library is acceptable if already in use.

## Test plan
- Write 0..4 with 1,64,128,4,256; write LAUNCH=1; ready held low for 3 cycles then high -> csr_reg_set_o={1,64,128,4,256} is stable through the 4-cycle valid window; exactly one handshake.
- Write addr 0 with 7 while PENDING -> req_ready=0 until the handshake; then the write lands and the next launch carries 7.
- Read RO addr 5 with csr_reg_ro_set_i[0]=0xDEAD -> rsp 0xDEAD one cycle later.
- rsp_ready low for 2 cycles on a read -> rsp held stable, req_ready=0, then recovers; no lost or duplicated response.
- Launch handshake, acc_busy_i high for 10 cycles -> PERF reads 10. Write PERF -> reads 0. Write LAUNCH=0 -> no valid raised.
- Read addr 100 -> rsp 0. Reset asserted during PENDING -> valid low next cycle, all RW regs read 0.

Source files
------------

// File: rtl/snax_simbacore_csr_pkg.sv
// Shared types and address-map helpers for the SimbaCore CSR manager.
package snax_simbacore_csr_pkg;

   typedef enum logic {
      IDLE,
      PENDING
   } csr_state_e;

   // Launch/status and perf registers sit directly after the RW and RO blocks.
   function automatic int unsigned launch_addr(input int unsigned rw_count, input int unsigned ro_count);
      return rw_count + ro_count;
   endfunction

   function automatic int unsigned perf_addr(input int unsigned rw_count, input int unsigned ro_count);
      return rw_count + ro_count + 1;
   endfunction

   localparam int unsigned StatusPendingBit = 0;
   localparam int unsigned StatusBusyBit    = 1;

endpackage

// File: rtl/snax_simbacore_csr_manager.sv
// Core-side CSR front end for SimbaCore: RW config registers, RO passthrough,
// launch handshake towards the accelerator and a busy-cycle perf counter.
module snax_simbacore_csr_manager
   import snax_simbacore_csr_pkg::*;
#(
   parameter int unsigned RegRWCount   = 5,
   parameter int unsigned RegROCount   = 2,
   parameter int unsigned RegDataWidth = 32,
   parameter int unsigned RegAddrWidth = 32
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic [RegAddrWidth-1:0]                  csr_req_addr_i,
   input  logic [RegDataWidth-1:0]                  csr_req_data_i,
   input  logic                                     csr_req_write_i,
   input  logic                                     csr_req_valid_i,
   output logic                                     csr_req_ready_o,
   output logic [RegDataWidth-1:0]                  csr_rsp_data_o,
   output logic                                     csr_rsp_valid_o,
   input  logic                                     csr_rsp_ready_i,
   output logic [RegRWCount-1:0][RegDataWidth-1:0]  csr_reg_set_o,
   output logic                                     csr_reg_set_valid_o,
   input  logic                                     csr_reg_set_ready_i,
   input  logic [RegROCount-1:0][RegDataWidth-1:0]  csr_reg_ro_set_i,
   input  logic                                     acc_busy_i
);

   localparam int unsigned LaunchAddr = launch_addr(RegRWCount, RegROCount);
   localparam int unsigned PerfAddr   = perf_addr(RegRWCount, RegROCount);

   csr_state_e                              state;
   logic [RegRWCount-1:0][RegDataWidth-1:0] regs;
   logic [RegDataWidth-1:0]                 rsp_data;
   logic [RegDataWidth-1:0]                 rdata;
   logic [RegDataWidth-1:0]                 perf_cnt;
   logic                                    rsp_valid;
   logic                                    set_valid;
   logic                                    armed;
   logic                                    seen_busy;
   logic                                    req_ready;
   logic                                    wr_hs;
   logic                                    rd_hs;
   logic                                    launch_req;
   logic                                    perf_clr;
   logic                                    set_hs;

   // Writes are held off while a launch is outstanding so the config stays frozen.
   assign req_ready  = !(rsp_valid && !csr_rsp_ready_i) && !((state == PENDING) && csr_req_write_i);
   assign wr_hs      = csr_req_valid_i && req_ready && csr_req_write_i;
   assign rd_hs      = csr_req_valid_i && req_ready && !csr_req_write_i;
   assign launch_req = wr_hs && (csr_req_addr_i == RegAddrWidth'(LaunchAddr)) && csr_req_data_i[0];
   assign perf_clr   = wr_hs && (csr_req_addr_i == RegAddrWidth'(PerfAddr));
   assign set_hs     = (state == PENDING) && csr_reg_set_ready_i;

   assign csr_req_ready_o     = req_ready;
   assign csr_rsp_data_o      = rsp_data;
   assign csr_rsp_valid_o     = rsp_valid;
   assign csr_reg_set_o       = regs;
   assign csr_reg_set_valid_o = set_valid;

   always_comb begin
      rdata = '0;
      for (int unsigned i = 0; i < RegRWCount; i++) begin
         if (csr_req_addr_i == RegAddrWidth'(i)) rdata = regs[i];
      end
      for (int unsigned i = 0; i < RegROCount; i++) begin
         if (csr_req_addr_i == RegAddrWidth'(RegRWCount + i)) rdata = csr_reg_ro_set_i[i];
      end
      if (csr_req_addr_i == RegAddrWidth'(LaunchAddr)) begin
         rdata[StatusPendingBit] = (state == PENDING);
         rdata[StatusBusyBit]    = acc_busy_i;
      end
      if (csr_req_addr_i == RegAddrWidth'(PerfAddr)) rdata = perf_cnt;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         regs <= '0;
      end else if (wr_hs) begin
         for (int unsigned i = 0; i < RegRWCount; i++) begin
            if (csr_req_addr_i == RegAddrWidth'(i)) regs[i] <= csr_req_data_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else if (rd_hs) begin
         rsp_valid <= 1'b1;
         rsp_data  <= rdata;
      end else if (csr_rsp_ready_i) begin
         rsp_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state     <= IDLE;
         set_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (launch_req) begin
                  state     <= PENDING;
                  set_valid <= 1'b1;
               end
            end
            PENDING: begin
               if (csr_reg_set_ready_i) begin
                  state     <= IDLE;
                  set_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               set_valid <= 1'b0;
            end
         endcase
      end
   end

   // Later assignments take priority: launch handshake re-arms, a PERF write always clears.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         perf_cnt  <= '0;
         armed     <= 1'b0;
         seen_busy <= 1'b0;
      end else begin
         if (armed && acc_busy_i) begin
            seen_busy <= 1'b1;
            if (perf_cnt != '1) perf_cnt <= perf_cnt + 1'b1;
         end
         if (armed && seen_busy && !acc_busy_i) armed <= 1'b0;
         if (set_hs) begin
            perf_cnt  <= '0;
            armed     <= 1'b1;
            seen_busy <= 1'b0;
         end
         if (perf_clr) perf_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_snax_simbacore_csr_manager.sv
// Self-checking bench for snax_simbacore_csr_manager: directed scenarios plus
// randomized traffic checked against a transaction-level reference model.
module tb_snax_simbacore_csr_manager;

   logic                  clk;
   logic                  rst_ni;
   logic [31:0]           req_addr;
   logic [31:0]           req_data;
   logic                  req_write;
   logic                  req_valid;
   logic                  req_ready;
   logic [31:0]           rsp_data;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [4:0][31:0]      reg_set;
   logic                  set_valid;
   logic                  set_ready;
   logic [1:0][31:0]      ro_set;
   logic                  busy;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // reference model state
   logic [31:0] m_regs [5];
   logic [31:0] m_cfg [5];
   bit          m_pending;
   logic [31:0] m_cnt;
   bit          m_armed;
   bit          m_seen;
   bit          m_rsp_valid;
   logic [31:0] m_rsp_data;

   // observation
   bit          last_hs;
   logic [31:0] last_rsp;
   logic [4:0][31:0] last_cfg;
   int unsigned valid_cycles;
   int unsigned set_hs_count;

   snax_simbacore_csr_manager #(
      .RegRWCount   (5),
      .RegROCount   (2),
      .RegDataWidth (32),
      .RegAddrWidth (32)
   ) dut (
      .clk_i               (clk),
      .rst_ni              (rst_ni),
      .csr_req_addr_i      (req_addr),
      .csr_req_data_i      (req_data),
      .csr_req_write_i     (req_write),
      .csr_req_valid_i     (req_valid),
      .csr_req_ready_o     (req_ready),
      .csr_rsp_data_o      (rsp_data),
      .csr_rsp_valid_o     (rsp_valid),
      .csr_rsp_ready_i     (rsp_ready),
      .csr_reg_set_o       (reg_set),
      .csr_reg_set_valid_o (set_valid),
      .csr_reg_set_ready_i (set_ready),
      .csr_reg_ro_set_i    (ro_set),
      .acc_busy_i          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (a < 5) return m_regs[a];
      if (a < 7) return ro_set[int'(a) - 5];
      if (a == 7) return {30'b0, busy, m_pending};
      if (a == 8) return m_cnt;
      return 32'h0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 5; i++) begin
         m_regs[i] = '0;
         m_cfg[i]  = '0;
      end
      m_pending   = 0;
      m_cnt       = '0;
      m_armed     = 0;
      m_seen      = 0;
      m_rsp_valid = 0;
      m_rsp_data  = '0;
   endtask

   // One clock cycle: present a request, check outputs mid-cycle, advance the model.
   task automatic cycle(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d);
      bit          exp_ready;
      bit          hs;
      logic [31:0] rd;
      req_valid = v;
      req_write = w;
      req_addr  = a;
      req_data  = d;
      @(negedge clk);
      exp_ready = !(m_rsp_valid && !rsp_ready) && !(m_pending && w);
      check("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
      check("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_rsp_valid});
      if (m_rsp_valid) check("rsp_data", rsp_data, m_rsp_data);
      check("set_valid", {31'b0, set_valid}, {31'b0, m_pending});
      if (m_pending) begin
         for (int i = 0; i < 5; i++) check("set_cfg", reg_set[i], m_cfg[i]);
      end
      if (set_valid) valid_cycles++;
      if (set_valid && set_ready) begin
         set_hs_count++;
         last_cfg = reg_set;
      end
      if (rsp_valid && rsp_ready) last_rsp = rsp_data;

      hs      = v && exp_ready;
      last_hs = hs;
      rd      = model_read(a);
      @(posedge clk);
      #1;
      // perf: count busy cycles after a launch until the first busy run ends
      if (m_armed && busy) begin
         m_seen = 1;
         if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end else if (m_armed && m_seen && !busy) begin
         m_armed = 0;
      end
      if (m_pending && set_ready) begin
         m_pending = 0;
         m_cnt     = 0;
         m_armed   = 1;
         m_seen    = 0;
      end
      if (hs && !w) begin
         m_rsp_valid = 1;
         m_rsp_data  = rd;
      end else if (rsp_ready) begin
         m_rsp_valid = 0;
      end
      if (hs && w) begin
         if (a < 5) m_regs[a] = d;
         if (a == 8) m_cnt = 0;
         if (a == 7 && d[0]) begin
            m_pending = 1;
            for (int i = 0; i < 5; i++) m_cfg[i] = m_regs[i];
         end
      end
   endtask

   task automatic idle();
      cycle(0, 0, 32'h0, 32'h0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bit done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         cycle(1, 1, a, d);
         done = last_hs;
      end
      if (!done) check("wr_timeout", 32'd0, 32'd1);
   endtask

   task automatic rd(input logic [31:0] a);
      bit done = 0;
      rsp_ready = 1;
      for (int i = 0; i < 40 && !done; i++) begin
         cycle(1, 0, a, 32'h0);
         done = last_hs;
      end
      if (!done) check("rd_timeout", 32'd0, 32'd1);
      idle();
   endtask

   task automatic do_reset();
      rst_ni    = 0;
      req_valid = 0;
      @(posedge clk);
      #1;
      rst_ni = 1;
      model_reset();
      check("rst_set_valid", {31'b0, set_valid}, 32'd0);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
   endtask

   initial begin
      logic [31:0] cfg_exp [5];
      int unsigned vc0;
      int unsigned hc0;
      bit          v;
      bit          w;
      logic [31:0] a;
      cfg_exp = '{32'd1, 32'd64, 32'd128, 32'd4, 32'd256};

      req_valid = 0;
      req_write = 0;
      req_addr  = '0;
      req_data  = '0;
      rsp_ready = 1;
      set_ready = 0;
      busy      = 0;
      ro_set    = '0;
      rst_ni    = 0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      check("rst_req_ready", {31'b0, req_ready}, 32'd1);

      // launch with a 4-cycle valid window
      for (int i = 0; i < 5; i++) wr(i, cfg_exp[i]);
      wr(7, 1);
      vc0 = valid_cycles;
      hc0 = set_hs_count;
      repeat (3) idle();
      set_ready = 1;
      idle();
      idle();
      check("valid_window", valid_cycles - vc0, 32'd4);
      check("launch_count", set_hs_count - hc0, 32'd1);
      for (int i = 0; i < 5; i++) check("launch_cfg", last_cfg[i], cfg_exp[i]);

      // write stalled while pending, lands afterwards
      set_ready = 0;
      wr(7, 1);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 1, 32'd0, 32'd7);
         check("stall_hs", {31'b0, last_hs}, 32'd0);
      end
      set_ready = 1;
      cycle(1, 1, 32'd0, 32'd7);
      check("stall_hs", {31'b0, last_hs}, 32'd0);
      wr(0, 7);
      wr(7, 1);
      idle();
      check("relaunch_cfg0", last_cfg[0], 32'd7);

      // RO passthrough
      ro_set[0] = 32'hDEAD;
      rd(5);
      check("ro_read", last_rsp, 32'hDEAD);

      // response back-pressure
      rsp_ready = 0;
      cycle(1, 0, 32'd1, 32'h0);
      cycle(1, 0, 32'd2, 32'h0);
      check("bp_blocked", {31'b0, last_hs}, 32'd0);
      idle();
      rsp_ready = 1;
      idle();
      check("bp_rsp", last_rsp, 32'd64);
      idle();

      // perf counter
      busy = 0;
      wr(7, 1);
      idle();
      busy = 1;
      repeat (10) idle();
      busy = 0;
      repeat (2) idle();
      rd(8);
      check("perf_10", last_rsp, 32'd10);
      wr(8, 32'h1234);
      rd(8);
      check("perf_clr", last_rsp, 32'd0);
      wr(7, 0);
      idle();
      check("launch0_novalid", {31'b0, set_valid}, 32'd0);

      rd(100);
      check("unmapped_rd", last_rsp, 32'd0);

      // reset during pending
      set_ready = 0;
      wr(7, 1);
      idle();
      do_reset();
      set_ready = 1;
      idle();
      for (int i = 0; i < 5; i++) begin
         rd(i);
         check("rst_reg", last_rsp, 32'd0);
      end

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rsp_ready = ($urandom % 4) != 0;
         set_ready = ($urandom % 3) == 0;
         if ($urandom % 6 == 0) busy = ~busy;
         if ($urandom % 16 == 0) ro_set = {$urandom, $urandom};
         v = $urandom % 2;
         w = $urandom % 2;
         a = ($urandom % 8 == 0) ? $urandom : ($urandom % 10);
         cycle(v, w, a, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
